tmds_decoder_align: RTL and testbench
=====================================

# tmds_decoder_align

Receive-side counterpart of the TMDS encoder lane in vga2dvid. It takes one unaligned 10-bit deserialized word per pixel clock from a single TMDS channel and finds the symbol boundary by hunting for DVI control tokens. It then decodes each aligned symbol into 8-bit pixel data or 2-bit control (C0/C1), with a data-enable flag. One instance per channel. The blue-channel instance's out_c carries hsync/vsync.

## Interface
Parameters:
- C_lock_tokens, 8: consecutive control tokens at one offset required to declare lock (2..255).
- C_timeout_bits, 12: width of the no-token timeout counter; timeout fires after 2^C_timeout_bits cycles (4096, longer than one 2200-pixel 1080p line).

Ports:
- clk_pixel  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high.
- in_raw  in  10  deserialized word; in_raw[0] is the earliest received bit.
- out_data  out  8  decoded pixel byte; 0 while out_de=0.
- out_c  out  2  {C1,C0} of the last control token; held during data periods.
- out_de  out  1  1 = out_data valid (data symbol), 0 = control period.
- out_locked  out  1  alignment locked.
- out_offset  out  4  current bit offset, 0..9.

## Operation
- Window: prev register holds the previous in_raw. win = {in_raw, prev} (20 bits). sym = win[offset+9 : offset].
- Control tokens (sym, bit 9..0): 1101010100 gives c=00, 0010101011 gives 01, 0101010100 gives 10, 1010101011 gives 11. is_ctl asserts on any of these four.
- Data decode, for any non-control sym:
  - d' = sym[9] ? ~sym[7:0] : sym[7:0].
  - d[0] = d'[0].
  - For i=1..7: d[i] = d'[i]^d'[i-1] if sym[8]=1; otherwise ~(d'[i]^d'[i-1]).
- Counters:
  - run: counts consecutive is_ctl cycles; cleared on a non-control cycle; saturates at C_lock_tokens.
  - tmo: C_timeout_bits wide; cleared on every is_ctl cycle; otherwise increments.
- FSM SEARCH (reset state):
  - run reaching C_lock_tokens moves to LOCKED.
  - Otherwise, tmo reaching all-ones advances offset (9 wraps to 0) and clears run and tmo.
  - If lock and timeout occur in the same cycle, lock wins and offset is unchanged.
- FSM LOCKED:
  - Offset is frozen.
  - tmo reaching all-ones moves to SEARCH, advances offset by 1 (with wrap), and clears run and tmo.
  - Isolated non-control or invalid symbols do not drop lock.
- Decode outputs update in every state. out_locked only qualifies their use.
- The offset change takes effect on the next sym evaluation. No extra flush cycle is inserted.

## Timing
- Reset values: out_data=0, out_c=0, out_de=0, out_locked=0, out_offset=0, prev=0, run=0, tmo=0, state=SEARCH.
- Reset applied mid-operation returns everything to these values on the next edge, regardless of state.
- Latency: in_raw sampled at edge N drives registered outputs valid after edge N+1. The pipeline is the prev register plus the output register.
- out_locked rises one cycle after the edge at which run reaches C_lock_tokens.
- out_locked falls together with the out_offset increment.
- Throughput: one symbol per clk_pixel, no stalls.

## Structure
- Shared package (tmds_pkg) holds:
  - The four control-token constants and their c mapping.
  - FSM state encoding (SEARCH, LOCKED).
  - The tmds_decode function, reused by a future TMDS/TERC4 receiver.
- One sub-module, tmds_symbol_decode: combinational sym to {is_ctl, c, d}. The top holds the window, counters, FSM and output registers.

## Test plan
- Aligned stream, offset 0: 20 tokens 1101010100, then data symbols.
  - out_locked rises after 8 tokens.
  - out_c=00, out_offset=0.
  - Encoder symbols for 0x00, 0xFF and 0x55 decode to out_data 0x00, 0xFF and 0x55 with out_de=1.
- Stream delayed by 7 bits, repeating 280 tokens / 1920 data per line.
  - out_offset steps 0..7, one step per 4096-cycle timeout.
  - Lock is reached at offset 7 and decoded data is correct.
- Locked, then data only for 4096 cycles.
  - out_locked drops and out_offset increments by 1.
  - Restoring tokens at the new true offset relocks.
- Offset wrap: stream misaligned by 9 bits, starting at offset 9 with no tokens.
  - After timeout, out_offset=0.
- Token 1010101011 followed by data.
  - out_c=11 holds through the data period.
  - out_de=0 during the token and out_data=0 there.
- Assert reset while LOCKED at offset 5.
  - Next cycle: all outputs 0 and state=SEARCH.
  - Relock succeeds within C_lock_tokens+1 cycles of valid tokens.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: DVI control tokens, aligner FSM encoding
// and the 10b-to-8b data decode used by every TMDS receiver lane.
package tmds_pkg;

  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
  function automatic logic [7:0] tmds_decode(input logic [9:0] sym);
    logic [7:0] dp;
    logic [7:0] d;
    dp   = sym[9] ? ~sym[7:0] : sym[7:0];
    d    = '0;
    d[0] = dp[0];
    for (int unsigned i = 1; i < 8; i++) begin
      d[i] = sym[8] ? (dp[i] ^ dp[i-1]) : ~(dp[i] ^ dp[i-1]);
    end
    return d;
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational classification of one aligned TMDS symbol into control
// token {is_ctl, c} or decoded data byte d.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym,
  output logic       is_ctl,
  output logic [1:0] c,
  output logic [7:0] d
);

  always_comb begin
    is_ctl = 1'b1;
    c      = '0;
    case (sym)
      TOKEN_C00: c = 2'b00;
      TOKEN_C01: c = 2'b01;
      TOKEN_C10: c = 2'b10;
      TOKEN_C11: c = 2'b11;
      default:   is_ctl = 1'b0;
    endcase
    d = tmds_decode(sym);
  end

endmodule

// File: rtl/tmds_decoder_align.sv
// One TMDS channel receiver: hunts for the symbol boundary using DVI control
// tokens, then decodes aligned symbols into pixel data or C0/C1 control.
module tmds_decoder_align
  import tmds_pkg::*;
#(
  parameter int unsigned C_lock_tokens  = 8,
  parameter int unsigned C_timeout_bits = 12
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [9:0] in_raw,
  output logic [7:0] out_data,
  output logic [1:0] out_c,
  output logic       out_de,
  output logic       out_locked,
  output logic [3:0] out_offset
);

  localparam int unsigned RUN_W = $clog2(C_lock_tokens + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(C_lock_tokens);

  logic [9:0]                prev;
  logic [19:0]               win;
  logic [19:0]               win_shift;
  logic [9:0]                sym;
  logic                      is_ctl;
  logic [1:0]                c;
  logic [7:0]                d;
  logic [RUN_W-1:0]          run;
  logic [C_timeout_bits-1:0] tmo;
  logic [0:0]                state;
  logic [3:0]                offset;
  logic [3:0]                offset_next;
  logic                      lock_hit;
  logic                      timeout;

  assign win         = {in_raw, prev};
  assign win_shift   = win >> offset;
  assign sym         = win_shift[9:0];
  assign lock_hit    = (run == RUN_MAX);
  assign timeout     = &tmo;
  assign offset_next = (offset == 4'd9) ? 4'd0 : offset + 4'd1;

  tmds_symbol_decode u_symbol_decode (
    .sym    (sym),
    .is_ctl (is_ctl),
    .c      (c),
    .d      (d)
  );

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      prev     <= '0;
      out_data <= '0;
      out_c    <= '0;
      out_de   <= 1'b0;
      run      <= '0;
      tmo      <= '0;
      state    <= ST_SEARCH;
      offset   <= '0;
    end else begin
      prev     <= in_raw;
      out_de   <= ~is_ctl;
      out_data <= is_ctl ? 8'h00 : d;
      if (is_ctl) begin
        out_c <= c;
      end

      if (is_ctl) begin
        run <= lock_hit ? run : run + RUN_W'(1);
        tmo <= '0;
      end else begin
        run <= '0;
        tmo <= tmo + C_timeout_bits'(1);
      end

      // Slip/unlock assignments below override the counter updates above.
      case (state)
        ST_SEARCH: begin
          if (lock_hit) begin
            state <= ST_LOCKED;
          end else if (timeout) begin
            offset <= offset_next;
            run    <= '0;
            tmo    <= '0;
          end
        end
        default: begin
          if (timeout) begin
            state  <= ST_SEARCH;
            offset <= offset_next;
            run    <= '0;
            tmo    <= '0;
          end
        end
      endcase
    end
  end

  assign out_locked = (state == ST_LOCKED);
  assign out_offset = offset;

endmodule

// File: tb/tb_tmds_decoder_align.sv
// Directed bench for tmds_decoder_align: alignment hunt, lock, timeout slip,
// offset wrap, control hold and data decode against hand-computed values.
module tb_tmds_decoder_align;

  localparam logic [9:0] T00  = 10'b1101010100;
  localparam logic [9:0] T11  = 10'b1010101011;
  localparam logic [9:0] S00  = 10'b0100000000;  // 0x00
  localparam logic [9:0] SFF  = 10'b0011111111;  // 0xFF
  localparam logic [9:0] S55  = 10'b0100110011;  // 0x55
  localparam logic [9:0] S55N = 10'b1111001100;  // 0x55, inverted form

  logic       clk_pixel = 1'b0;
  logic       reset;
  logic [9:0] in_raw;
  logic [7:0] out_data;
  logic [1:0] out_c;
  logic       out_de;
  logic       out_locked;
  logic [3:0] out_offset;

  int n_cmp = 0;
  int n_err = 0;
  int delay = 0;
  int pos   = 0;
  logic [9:0] prev_sym;

  always #5 clk_pixel = ~clk_pixel;

  tmds_decoder_align #(
    .C_lock_tokens  (8),
    .C_timeout_bits (12)
  ) dut (
    .clk_pixel  (clk_pixel),
    .reset      (reset),
    .in_raw     (in_raw),
    .out_data   (out_data),
    .out_c      (out_c),
    .out_de     (out_de),
    .out_locked (out_locked),
    .out_offset (out_offset)
  );

  // Serial stream delayed by 'delay' bits, cut into 10-bit words.
  task automatic send(input logic [9:0] s);
    logic [19:0] w;
    w      = {s, prev_sym} >> (10 - delay);
    in_raw = w[9:0];
    @(posedge clk_pixel);
    #1;
    prev_sym = s;
  endtask

  // One pixel of a line: 280 control tokens then 1920 data symbols.
  task automatic line_step();
    send((pos < 280) ? T00 : S00);
    pos = (pos == 2199) ? 0 : pos + 1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    send(T00);
    reset    = 1'b0;
    prev_sym = '0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    in_raw = T00;
    repeat (3) @(posedge clk_pixel);
    #1;
    reset = 1'b0;
    n_cmp++;
    if ({out_data, out_c, out_de, out_locked, out_offset} !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_state got %h want 0000", {out_data, out_c, out_de, out_locked, out_offset});
    end
  endtask

  task automatic test_aligned();
    delay = 0;
    do_reset();
    repeat (9) send(T00);
    n_cmp++;
    if (out_locked !== 1'b0) begin
      n_err++;
      $display("FAIL aligned_prelock got %b want 0", out_locked);
    end
    send(T00);
    n_cmp++;
    if ({out_locked, out_offset, out_c, out_de} !== {1'b1, 4'd0, 2'b00, 1'b0}) begin
      n_err++;
      $display("FAIL aligned_lock got lk=%b off=%0d c=%b de=%b want 1 0 00 0", out_locked, out_offset, out_c, out_de);
    end
    repeat (10) send(T00);
    send(S00);
    send(SFF);
    n_cmp++;
    if ({out_data, out_de, out_c} !== {8'h00, 1'b1, 2'b00}) begin
      n_err++;
      $display("FAIL data_00 got d=%h de=%b c=%b want 00 1 00", out_data, out_de, out_c);
    end
    send(S55);
    n_cmp++;
    if ({out_data, out_de} !== {8'hFF, 1'b1}) begin
      n_err++;
      $display("FAIL data_ff got d=%h de=%b want ff 1", out_data, out_de);
    end
    send(S55N);
    n_cmp++;
    if ({out_data, out_de} !== {8'h55, 1'b1}) begin
      n_err++;
      $display("FAIL data_55 got d=%h de=%b want 55 1", out_data, out_de);
    end
    send(T00);
    n_cmp++;
    if ({out_data, out_de} !== {8'h55, 1'b1}) begin
      n_err++;
      $display("FAIL data_55_inv got d=%h de=%b want 55 1", out_data, out_de);
    end
    send(T00);
    n_cmp++;
    if ({out_data, out_de, out_c, out_locked} !== {8'h00, 1'b0, 2'b00, 1'b1}) begin
      n_err++;
      $display("FAIL aligned_ctl got d=%h de=%b c=%b lk=%b want 00 0 00 1", out_data, out_de, out_c, out_locked);
    end
  endtask

  task automatic test_ctl_hold();
    send(T11);
    send(T11);
    n_cmp++;
    if ({out_data, out_de, out_c} !== {8'h00, 1'b0, 2'b11}) begin
      n_err++;
      $display("FAIL ctl11_token got d=%h de=%b c=%b want 00 0 11", out_data, out_de, out_c);
    end
    send(T11);
    send(S55);
    send(SFF);
    n_cmp++;
    if ({out_data, out_de, out_c} !== {8'h55, 1'b1, 2'b11}) begin
      n_err++;
      $display("FAIL ctl11_hold1 got d=%h de=%b c=%b want 55 1 11", out_data, out_de, out_c);
    end
    send(S00);
    send(T00);
    n_cmp++;
    if ({out_data, out_de, out_c, out_locked} !== {8'h00, 1'b1, 2'b11, 1'b1}) begin
      n_err++;
      $display("FAIL ctl11_hold2 got d=%h de=%b c=%b lk=%b want 00 1 11 1", out_data, out_de, out_c, out_locked);
    end
    send(T00);
    n_cmp++;
    if ({out_de, out_c} !== {1'b0, 2'b00}) begin
      n_err++;
      $display("FAIL ctl00_return got de=%b c=%b want 0 00", out_de, out_c);
    end
  endtask

  task automatic test_search_delay7();
    int cyc;
    int steps;
    logic [3:0] last_off;
    delay    = 7;
    do_reset();
    pos      = 0;
    cyc      = 0;
    steps    = 0;
    last_off = 4'd0;
    while (cyc < 40000 && out_locked !== 1'b1) begin
      line_step();
      cyc++;
      if (out_offset !== last_off) begin
        n_cmp++;
        if (out_offset !== last_off + 4'd1 || cyc != 4096 * (steps + 1)) begin
          n_err++;
          $display("FAIL search_step got off=%0d cyc=%0d want off=%0d cyc=%0d",
                   out_offset, cyc, last_off + 4'd1, 4096 * (steps + 1));
        end
        steps++;
        last_off = out_offset;
      end
    end
    n_cmp++;
    if ({out_locked, out_offset} !== {1'b1, 4'd7} || steps != 7) begin
      n_err++;
      $display("FAIL search_lock7 got lk=%b off=%0d steps=%0d want 1 7 7", out_locked, out_offset, steps);
    end
    cyc = 0;
    while (cyc < 2200 && pos != 282) begin
      line_step();
      cyc++;
    end
    n_cmp++;
    if ({out_data, out_de, out_c, out_offset} !== {8'h00, 1'b1, 2'b00, 4'd7}) begin
      n_err++;
      $display("FAIL delay7_data got d=%h de=%b c=%b off=%0d want 00 1 00 7", out_data, out_de, out_c, out_offset);
    end
  endtask

  task automatic test_timeout_relock();
    int j;
    send(T00);
    send(T00);
    j = 0;
    while (j < 5000 && out_locked === 1'b1) begin
      send(S00);
      j++;
      if (j == 4096) begin
        n_cmp++;
        if (out_locked !== 1'b1) begin
          n_err++;
          $display("FAIL tmo_early got lk=%b at 4096 want 1", out_locked);
        end
      end
    end
    n_cmp++;
    if (j != 4097 || {out_locked, out_offset} !== {1'b0, 4'd8}) begin
      n_err++;
      $display("FAIL tmo_drop got cyc=%0d lk=%b off=%0d want 4097 0 8", j, out_locked, out_offset);
    end
    delay = 8;
    j = 0;
    while (j < 20 && out_locked !== 1'b1) begin
      send(T00);
      j++;
    end
    n_cmp++;
    if (j != 10 || {out_locked, out_offset} !== {1'b1, 4'd8}) begin
      n_err++;
      $display("FAIL relock8 got cyc=%0d lk=%b off=%0d want 10 1 8", j, out_locked, out_offset);
    end
  endtask

  task automatic test_wrap();
    int j;
    j = 0;
    while (j < 5000 && out_locked === 1'b1) begin
      send(S00);
      j++;
    end
    n_cmp++;
    if (j != 4097 || {out_locked, out_offset} !== {1'b0, 4'd9}) begin
      n_err++;
      $display("FAIL to_off9 got cyc=%0d lk=%b off=%0d want 4097 0 9", j, out_locked, out_offset);
    end
    delay = 9;
    j = 0;
    while (j < 5000 && out_offset === 4'd9) begin
      send(S00);
      j++;
    end
    n_cmp++;
    if (j != 4096 || {out_locked, out_offset} !== {1'b0, 4'd0}) begin
      n_err++;
      $display("FAIL wrap got cyc=%0d lk=%b off=%0d want 4096 0 0", j, out_locked, out_offset);
    end
  endtask

  task automatic test_reset_locked();
    int j;
    delay = 5;
    pos   = 0;
    j     = 0;
    while (j < 30000 && out_locked !== 1'b1) begin
      line_step();
      j++;
    end
    n_cmp++;
    if ({out_locked, out_offset} !== {1'b1, 4'd5}) begin
      n_err++;
      $display("FAIL lock5 got lk=%b off=%0d want 1 5", out_locked, out_offset);
    end
    repeat (300) line_step();
    delay = 0;
    do_reset();
    n_cmp++;
    if ({out_data, out_c, out_de, out_locked, out_offset} !== 16'h0000) begin
      n_err++;
      $display("FAIL midrun_reset got %h want 0000", {out_data, out_c, out_de, out_locked, out_offset});
    end
    repeat (9) send(T00);
    n_cmp++;
    if (out_locked !== 1'b0) begin
      n_err++;
      $display("FAIL relock_early got lk=%b want 0", out_locked);
    end
    send(T00);
    n_cmp++;
    if ({out_locked, out_offset} !== {1'b1, 4'd0}) begin
      n_err++;
      $display("FAIL relock0 got lk=%b off=%0d want 1 0", out_locked, out_offset);
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_raw   = '0;
    prev_sym = '0;
    test_reset();
    test_aligned();
    test_ctl_hold();
    test_search_delay7();
    test_timeout_relock();
    test_wrap();
    test_reset_locked();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
